// File: rtl/tree_node_arbiter.sv
// tree_node_arbiter: merges NUM_CH child channels into one upstream stream.
// Each lane has a DEPTH-entry FIFO. A round-robin arbiter drains the lanes
// into a registered output slot. The slot is tagged with the source channel.
//
// Ports:
//   clk, rst_n  : single clock, asynchronous active-low reset
//   in_valid    : per-channel push request
//   in_data     : channel c payload at [c*DATA_W +: DATA_W]
//   in_ready    : per-channel ready (FIFO not full)
//   out_valid   : output slot holds a word
//   out_data    : payload of the output slot
//   out_id      : source channel of out_data
//   out_ready   : upstream accepts the output slot
//   fifo_full   : per-channel full flag (from registered pointers)
//   fifo_empty  : per-channel empty flag (from registered pointers)
module tree_node_arbiter #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        fifo_full,
  output logic [NUM_CH-1:0]        fifo_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = ID_W + 1;

  logic [DATA_W-1:0] head [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic [SW-1:0]     scan;
  logic              any_ne;
  logic              slot_free;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = ~fifo_full;

  // Per-lane FIFO: pointers carry one extra wrap bit to tell full from empty.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;

    assign fifo_empty[c] = (wptr == rptr);
    assign fifo_full[c]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push[c]       = in_valid[c] && !fifo_full[c];
    assign pop[c]        = slot_free && any_ne && (grant == ID_W'(c));
    assign head[c]       = mem[rptr[AW-1:0]];

    // Pointer update; a push and a pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push[c]) wptr <= wptr + PW'(1);
        if (pop[c])  rptr <= rptr + PW'(1);
      end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
      if (push[c]) mem[wptr[AW-1:0]] <= in_data[c*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: first non-empty lane starting at ptr, wrapping at NUM_CH.
  always_comb begin
    any_ne = 1'b0;
    grant  = '0;
    scan   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan = {1'b0, ptr} + SW'(i);
      if (scan >= SW'(NUM_CH)) scan = scan - SW'(NUM_CH);
      if (!any_ne && !fifo_empty[ID_W'(scan)]) begin
        any_ne = 1'b1;
        grant  = ID_W'(scan);
      end
    end
  end

  // Output slot: loads on a grant, empties when nothing is pending, holds on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (slot_free) begin
      if (any_ne) begin
        out_valid <= 1'b1;
        out_data  <= head[grant];
        out_id    <= grant;
        ptr       <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + ID_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
